// File: rtl/adc_paddle_ctrl.sv
// adc_paddle_ctrl: XADC DRP reader, IIR filter, hysteresis and debounce driving Pong paddle buttons.
// Optional ADC_PADDLE_PRIORITY_EN: on a both-pressed conflict the most recently pressed channel wins.
module adc_paddle_ctrl #(
    parameter logic [6:0]  ADDR_L      = 7'h13,
    parameter logic [6:0]  ADDR_R      = 7'h12,
    parameter int          FILT_SHIFT  = 2,
    parameter logic [11:0] TH_ON       = 12'd2600,
    parameter logic [11:0] TH_OFF      = 12'd1500,
    parameter int          DEB_SAMPLES = 4,
    parameter int          TIMEOUT     = 255
) (
    input  logic        CLK100MHZ,
    input  logic        RST_BTN,
    input  logic        adc_eoc,
    output logic        drp_den,
    output logic [6:0]  drp_daddr,
    input  logic        drp_drdy,
    input  logic [15:0] drp_do,
    output logic [1:0]  BTN_LR,
    output logic [1:0]  LED,
    output logic [11:0] sample_l,
    output logic [11:0] sample_r,
    output logic        drp_err
);
    localparam int CW = $clog2(DEB_SAMPLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_PROC} state_t;

    state_t         r_state;
    logic           r_ch;
    logic [11:0]    r_smp;
    logic [TW-1:0]  r_wcnt;
    logic [11:0]    r_avg [2];
    logic [CW-1:0]  r_cnt [2];
    logic [1:0]     r_st;
`ifdef ADC_PADDLE_PRIORITY_EN
    logic           r_last;
`endif

    logic [11:0]        w_avg;
    logic signed [12:0] w_diff;
    logic signed [12:0] w_step;
    logic signed [13:0] w_sum;
    logic [11:0]        w_new;
    logic               w_want;
    logic               w_flip;
    logic               w_unused;

    // Index 1 is the left channel, 0 the right, matching the BTN_LR bit order.
    assign w_avg    = r_avg[r_ch];
    assign w_diff   = $signed({1'b0, r_smp}) - $signed({1'b0, w_avg});
    assign w_step   = w_diff >>> FILT_SHIFT;
    assign w_sum    = $signed({2'b00, w_avg}) + $signed({w_step[12], w_step});
    assign w_new    = w_sum < 14'sd0 ? 12'd0 : w_sum > 14'sd4095 ? 12'd4095 : w_sum[11:0];
    assign w_want   = w_new >= TH_ON ? 1'b1 : w_new < TH_OFF ? 1'b0 : r_st[r_ch];
    assign w_flip   = r_cnt[r_ch] == CW'(DEB_SAMPLES - 1);
    assign w_unused = &{1'b0, drp_do[3:0]};

    assign sample_l = r_avg[1];
    assign sample_r = r_avg[0];
`ifdef ADC_PADDLE_PRIORITY_EN
    assign BTN_LR = &r_st ? (r_last ? 2'b10 : 2'b01) : r_st;
`else
    assign BTN_LR = &r_st ? 2'b00 : r_st;
`endif
    assign LED = BTN_LR;

    always_ff @(posedge CLK100MHZ or negedge RST_BTN) begin
        if (!RST_BTN) begin
            r_state   <= S_IDLE;
            r_ch      <= 1'b1;
            r_smp     <= '0;
            r_wcnt    <= '0;
            r_st      <= '0;
            drp_den   <= 1'b0;
            drp_daddr <= '0;
            drp_err   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_avg[i] <= '0;
                r_cnt[i] <= '0;
            end
`ifdef ADC_PADDLE_PRIORITY_EN
            r_last    <= 1'b1;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (adc_eoc) begin
                    r_state   <= S_REQ;
                    drp_den   <= 1'b1;
                    drp_daddr <= r_ch ? ADDR_L : ADDR_R;
                end
                S_REQ: begin
                    r_state   <= S_WAIT;
                    drp_den   <= 1'b0;
                    drp_daddr <= '0;
                    r_wcnt    <= '0;
                end
                S_WAIT: if (drp_drdy) begin
                    r_state <= S_PROC;
                    r_smp   <= drp_do[15:4];
                end else if (r_wcnt == TW'(TIMEOUT)) begin
                    r_state <= S_IDLE;
                    drp_err <= 1'b1;
                    r_ch    <= ~r_ch;
                end else begin
                    r_wcnt <= r_wcnt + 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_ch        <= ~r_ch;
                    r_avg[r_ch] <= w_new;
                    if (w_want == r_st[r_ch]) begin
                        r_cnt[r_ch] <= '0;
                    end else if (w_flip) begin
                        r_st[r_ch]  <= w_want;
                        r_cnt[r_ch] <= '0;
`ifdef ADC_PADDLE_PRIORITY_EN
                        if (w_want) r_last <= r_ch;
`endif
                    end else begin
                        r_cnt[r_ch] <= r_cnt[r_ch] + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule
